// File: rtl/button_press_classifier_pkg.sv
// Shared definitions for the button gesture classifier: state encoding and default timings.
package button_press_classifier_pkg;

  localparam int unsigned LongCyclesDefault = 100_000_000;
  localparam int unsigned GapCyclesDefault  = 25_000_000;
  localparam int unsigned CntWDefault       = 27;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StPress1 = 3'd1,
    StGap    = 3'd2,
    StPress2 = 3'd3,
    StHold   = 3'd4
  } state_e;

endpackage

// File: rtl/button_press_classifier.sv
// Classifies a debounced button level into short, long and double press pulses.
module button_press_classifier
  import button_press_classifier_pkg::*;
#(
  parameter int unsigned LONG_CYCLES = LongCyclesDefault,
  parameter int unsigned GAP_CYCLES  = GapCyclesDefault,
  parameter int unsigned CNT_W       = CntWDefault
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_db,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic busy
);

  localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GapLast  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             btn_prev_q;

  // btn_prev resets high so a button held through reset must be released first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      btn_prev_q   <= 1'b1;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      busy         <= 1'b0;
    end else begin
      btn_prev_q   <= btn_db;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      case (state_q)
        StIdle: begin
          busy <= 1'b0;
          if (btn_db && !btn_prev_q) begin
            state_q <= StPress1;
            cnt_q   <= '0;
            busy    <= 1'b1;
          end
        end
        StPress1: begin
          busy <= 1'b1;
          if (!btn_db) begin
            state_q <= StGap;
            cnt_q   <= '0;
          end else if (cnt_q == LongLast) begin
            state_q    <= StHold;
            long_press <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StGap: begin
          busy <= 1'b1;
          if (btn_db) begin
            state_q <= StPress2;
            cnt_q   <= '0;
          end else if (cnt_q == GapLast) begin
            state_q     <= StIdle;
            short_press <= 1'b1;
            busy        <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StPress2: begin
          busy <= 1'b1;
          if (!btn_db) begin
            state_q      <= StIdle;
            double_press <= 1'b1;
            busy         <= 1'b0;
          end else if (cnt_q == LongLast) begin
            // A long second press overrides the pending double press.
            state_q    <= StHold;
            long_press <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StHold: begin
          busy <= 1'b1;
          if (!btn_db) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_press_classifier.sv
// Self-checking bench: directed gesture scenarios plus random traffic against a run-length model.
module tb_button_press_classifier;

  localparam int L = 20;
  localparam int G = 8;
  localparam int N = 1000;

  logic clk, reset, btn_db;
  logic short_press, long_press, double_press, busy;
  int   total, bad;

  bit seq [N];
  bit es  [N];
  bit el  [N];
  bit ed  [N];
  bit eb  [N];

  button_press_classifier #(
    .LONG_CYCLES(L),
    .GAP_CYCLES (G),
    .CNT_W      (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_db      (btn_db),
    .short_press (short_press),
    .long_press  (long_press),
    .double_press(double_press),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gesture pulses must be mutually exclusive in every cycle.
  always @(negedge clk) begin
    total++;
    if ($countones({short_press, long_press, double_press}) > 1) begin
      bad++;
      $display("FAIL onehot t=%0t got s/l/d=%b%b%b want at most one", $time, short_press,
               long_press, double_press);
    end
  end

  // Drive one level; on return the outputs reflect the edge that sampled it.
  task automatic tick(input logic v);
    btn_db = v;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    btn_db = 1'b0;
    @(negedge clk);
    total++;
    if ({short_press, long_press, double_press, busy} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0000",
               {short_press, long_press, double_press, busy});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(1'b0);
      total++;
      if ({short_press, long_press, double_press, busy} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_idle k=%0d got=%b want=0000", k,
                 {short_press, long_press, double_press, busy});
      end
    end
  endtask

  task automatic test_short();
    logic [3:0] exp;
    for (int k = 0; k < 5; k++) begin
      tick(1'b1);
      total++;
      if ({short_press, long_press, double_press, busy} !== 4'b0001) begin
        bad++;
        $display("FAIL short_press_phase k=%0d got=%b want=0001", k,
                 {short_press, long_press, double_press, busy});
      end
    end
    for (int k = 0; k < 12; k++) begin
      tick(1'b0);
      exp = {k == 8, 1'b0, 1'b0, k < 8};
      total++;
      if ({short_press, long_press, double_press, busy} !== exp) begin
        bad++;
        $display("FAIL short_gap k=%0d got=%b want=%b", k,
                 {short_press, long_press, double_press, busy}, exp);
      end
    end
  endtask

  task automatic test_long();
    logic [3:0] exp;
    for (int k = 0; k < 25; k++) begin
      tick(1'b1);
      exp = {1'b0, k == L, 1'b0, 1'b1};
      total++;
      if ({short_press, long_press, double_press, busy} !== exp) begin
        bad++;
        $display("FAIL long_hold k=%0d got=%b want=%b", k,
                 {short_press, long_press, double_press, busy}, exp);
      end
    end
    for (int k = 0; k < 12; k++) begin
      tick(1'b0);
      total++;
      if ({short_press, long_press, double_press, busy} !== 4'b0000) begin
        bad++;
        $display("FAIL long_release k=%0d got=%b want=0000", k,
                 {short_press, long_press, double_press, busy});
      end
    end
  endtask

  task automatic test_double();
    for (int k = 0; k < 11; k++) begin
      tick(k < 4 || k >= 7);
      total++;
      if ({short_press, long_press, double_press, busy} !== 4'b0001) begin
        bad++;
        $display("FAIL double_body k=%0d got=%b want=0001", k,
                 {short_press, long_press, double_press, busy});
      end
    end
    tick(1'b0);
    total++;
    if ({short_press, long_press, double_press, busy} !== 4'b0010) begin
      bad++;
      $display("FAIL double_pulse got=%b want=0010",
               {short_press, long_press, double_press, busy});
    end
    for (int k = 0; k < 12; k++) begin
      tick(1'b0);
      total++;
      if ({short_press, long_press, double_press, busy} !== 4'b0000) begin
        bad++;
        $display("FAIL double_after k=%0d got=%b want=0000", k,
                 {short_press, long_press, double_press, busy});
      end
    end
  endtask

  task automatic test_double_to_long();
    logic [3:0] exp;
    for (int k = 0; k < 7; k++) tick(k < 4);
    for (int k = 0; k < 30; k++) begin
      tick(1'b1);
      exp = {1'b0, k == L, 1'b0, 1'b1};
      total++;
      if ({short_press, long_press, double_press, busy} !== exp) begin
        bad++;
        $display("FAIL dbl_long_hold k=%0d got=%b want=%b", k,
                 {short_press, long_press, double_press, busy}, exp);
      end
    end
    for (int k = 0; k < 12; k++) begin
      tick(1'b0);
      total++;
      if ({short_press, long_press, double_press, busy} !== 4'b0000) begin
        bad++;
        $display("FAIL dbl_long_release k=%0d got=%b want=0000", k,
                 {short_press, long_press, double_press, busy});
      end
    end
  endtask

  task automatic test_held_through_reset();
    logic [3:0] exp;
    btn_db = 1'b1;
    reset  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 32; k++) begin
      tick(k < 30);
      total++;
      if ({short_press, long_press, double_press, busy} !== 4'b0000) begin
        bad++;
        $display("FAIL held_reset k=%0d got=%b want=0000", k,
                 {short_press, long_press, double_press, busy});
      end
    end
    for (int k = 0; k < 5; k++) begin
      tick(1'b1);
      total++;
      if ({short_press, long_press, double_press, busy} !== 4'b0001) begin
        bad++;
        $display("FAIL held_reset_entry k=%0d got=%b want=0001", k,
                 {short_press, long_press, double_press, busy});
      end
    end
    for (int k = 0; k < 10; k++) begin
      tick(1'b0);
      exp = {k == G, 1'b0, 1'b0, k < G};
      total++;
      if ({short_press, long_press, double_press, busy} !== exp) begin
        bad++;
        $display("FAIL held_reset_short k=%0d got=%b want=%b", k,
                 {short_press, long_press, double_press, busy}, exp);
      end
    end
  endtask

  task automatic test_reset_mid_gap();
    for (int k = 0; k < 10; k++) tick(k < 4);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({short_press, long_press, double_press, busy} !== 4'b0000) begin
      bad++;
      $display("FAIL mid_gap_reset got=%b want=0000",
               {short_press, long_press, double_press, busy});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick(1'b0);
      total++;
      if ({short_press, long_press, double_press, busy} !== 4'b0000) begin
        bad++;
        $display("FAIL mid_gap_after k=%0d got=%b want=0000", k,
                 {short_press, long_press, double_press, busy});
      end
    end
  endtask

  function automatic int run_len(input int start, input bit v);
    int n = 0;
    while (start + n < N && seq[start+n] == v) n++;
    return n;
  endfunction

  // Gesture model from run lengths: press >= L+1 samples is long, gap >= G+1 zeros is short.
  task automatic build_expected();
    int i, p, r, g, s, q, e;
    for (int k = 0; k < N; k++) begin
      es[k] = 1'b0; el[k] = 1'b0; ed[k] = 1'b0; eb[k] = 1'b0;
    end
    i = 1;
    while (i < N) begin
      if (seq[i] && !seq[i-1]) begin
        p = run_len(i, 1'b1);
        if (p >= L + 1) begin
          if (i + L < N) el[i+L] = 1'b1;
          e = i + p;
        end else begin
          r = i + p;
          g = run_len(r, 1'b0);
          if (g >= G + 1) begin
            if (r + G < N) es[r+G] = 1'b1;
            e = r + G;
          end else begin
            s = r + g;
            q = run_len(s, 1'b1);
            if (q >= L + 1) begin
              if (s + L < N) el[s+L] = 1'b1;
            end else if (s + q < N) begin
              ed[s+q] = 1'b1;
            end
            e = s + q;
          end
        end
        for (int b = i; b < e && b < N; b++) eb[b] = 1'b1;
        i = e + 1;
      end else begin
        i++;
      end
    end
  endtask

  task automatic test_random();
    int k, len;
    k = 0;
    while (k < N - 40) begin
      len = int'($urandom_range(1, G + 3));
      if ($urandom_range(0, 3) == 0) len = len + G;
      for (int j = 0; j < len && k < N; j++) begin seq[k] = 1'b0; k++; end
      len = int'($urandom_range(1, L + 4));
      for (int j = 0; j < len && k < N - 40; j++) begin seq[k] = 1'b1; k++; end
    end
    while (k < N) begin seq[k] = 1'b0; k++; end
    seq[0] = 1'b0;
    build_expected();
    for (int c = 0; c < N; c++) begin
      tick(seq[c]);
      total++;
      if ({short_press, long_press, double_press, busy} !== {es[c], el[c], ed[c], eb[c]}) begin
        bad++;
        $display("FAIL random c=%0d got s/l/d/b=%b want=%b", c,
                 {short_press, long_press, double_press, busy}, {es[c], el[c], ed[c], eb[c]});
      end
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    btn_db = 1'b0;
    test_reset();
    test_short();
    test_long();
    test_double();
    test_double_to_long();
    test_held_through_reset();
    test_reset_mid_gap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
